hazard_tracker: RTL and testbench



---
 rtl/hazard_tracker_pkg.sv | 46 ++++
 rtl/hazard_match.sv | 52 +++++
 rtl/hazard_tracker.sv | 139 +++++++++++++
 tb/tb_hazard_tracker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_tracker_pkg.sv
// Shared stage codes, forwarding-select encodings and the shadow pipeline record
// used by the hazard tracker, decoder timing interface and datapath muxes.
package hazard_tracker_pkg;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned T_W    = 4;

   localparam logic [T_W-1:0] STG_D  = 4'd0;
   localparam logic [T_W-1:0] STG_E  = 4'd1;
   localparam logic [T_W-1:0] STG_M  = 4'd2;
   localparam logic [T_W-1:0] STG_W  = 4'd3;
   localparam logic [T_W-1:0] T_NONE = 4'hF;

   // D-stage operand mux selects
   localparam logic [1:0] FWD_D_GRF = 2'd0;
   localparam logic [1:0] FWD_D_E   = 2'd1;
   localparam logic [1:0] FWD_D_M   = 2'd2;
   localparam logic [1:0] FWD_D_W   = 2'd3;

   // E-stage operand mux selects
   localparam logic [1:0] FWD_E_IDEX = 2'd0;
   localparam logic [1:0] FWD_E_M    = 2'd1;
   localparam logic [1:0] FWD_E_W    = 2'd2;

   // M-stage store-data mux select
   localparam logic FWD_M_EXMEM = 1'b0;
   localparam logic FWD_M_W     = 1'b1;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [T_W-1:0]    t_rs;
      logic [T_W-1:0]    t_rt;
      logic [REG_AW-1:0] dst;
      logic [T_W-1:0]    t;
   } hz_rec_t;

   localparam hz_rec_t REC_NONE = '0;

   // A record produces register a; $0 and "never produced" results never match.
   function automatic logic produces(hz_rec_t r, logic [REG_AW-1:0] a);
      return r.valid && (r.dst == a) && (a != '0) && (r.t != T_NONE);
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand hazard check: stall request and nearest-ready-producer select against
// the E/M/W shadow records. Unused stages are fed REC_NONE by the caller.
module hazard_match
   import hazard_tracker_pkg::*;
(
   input  logic [REG_AW-1:0] addr,
   input  logic [T_W-1:0]    use_t,
   input  hz_rec_t           rec_e,
   input  hz_rec_t           rec_m,
   input  hz_rec_t           rec_w,
   output logic              stall_req,
   output logic [1:0]        fwd_sel
);

   logic           match_e, match_m, match_w;
   logic [T_W:0]   use_w, t_e, t_m;

   assign match_e = produces(rec_e, addr);
   assign match_m = produces(rec_m, addr);
   assign match_w = produces(rec_w, addr);

   assign use_w = {1'b0, use_t};
   assign t_e   = {1'b0, rec_e.t};
   assign t_m   = {1'b0, rec_m.t};

   // t - k > u rewritten as t > u + k to stay unsigned
   always_comb begin
      stall_req = 1'b0;
      if (use_t != T_NONE) begin
         stall_req = (match_e && (t_e > use_w + {1'b0, STG_E})) ||
                     (match_m && (t_m > use_w + {1'b0, STG_M}));
      end
   end

   // Nearest matching stage decides; a not-ready one blocks older stages.
   always_comb begin
      fwd_sel = FWD_D_GRF;
      if (match_e) begin
         if (rec_e.t <= STG_E) fwd_sel = FWD_D_E;
      end else if (match_m) begin
         if (rec_m.t <= STG_M) fwd_sel = FWD_D_M;
      end else if (match_w) begin
         if (rec_w.t <= STG_W) fwd_sel = FWD_D_W;
      end
   end

   logic unused_fields;
   assign unused_fields = ^{rec_e.rs, rec_e.rt, rec_e.t_rs, rec_e.t_rt,
                            rec_m.rs, rec_m.rt, rec_m.t_rs, rec_m.t_rt,
                            rec_w.rs, rec_w.rt, rec_w.t_rs, rec_w.t_rt};

endmodule

// File: rtl/hazard_tracker.sv
// Stall and forwarding control for the five-stage MIPS pipeline, driven by shadow
// records of the E/M/W instructions that shift in step with the pipeline registers.
module hazard_tracker
   import hazard_tracker_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              d_valid,
   input  logic [REG_AW-1:0] d_rs,
   input  logic [REG_AW-1:0] d_rt,
   input  logic [REG_AW-1:0] d_dst,
   input  logic [T_W-1:0]    d_t_rs,
   input  logic [T_W-1:0]    d_t_rt,
   input  logic [T_W-1:0]    d_t,
   output logic              stall,
   output logic [1:0]        fwd_d_rs,
   output logic [1:0]        fwd_d_rt,
   output logic [1:0]        fwd_e_rs,
   output logic [1:0]        fwd_e_rt,
   output logic              fwd_m_rt,
   output logic [CNT_W-1:0]  stall_cnt
);

   hz_rec_t          e_q, m_q, w_q, e_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             req_rs, req_rt;
   logic             req_e_rs, req_e_rt, req_m_rt;
   logic [1:0]       sel_e_rs, sel_e_rt, sel_m_rt;

   hazard_match u_match_d_rs (
      .addr      (d_rs),
      .use_t     (d_t_rs),
      .rec_e     (e_q),
      .rec_m     (m_q),
      .rec_w     (w_q),
      .stall_req (req_rs),
      .fwd_sel   (fwd_d_rs)
   );

   hazard_match u_match_d_rt (
      .addr      (d_rt),
      .use_t     (d_t_rt),
      .rec_e     (e_q),
      .rec_m     (m_q),
      .rec_w     (w_q),
      .stall_req (req_rt),
      .fwd_sel   (fwd_d_rt)
   );

   // E and M consumers only see older stages; their stall outputs are meaningless.
   hazard_match u_match_e_rs (
      .addr      (e_q.rs),
      .use_t     (e_q.t_rs),
      .rec_e     (REC_NONE),
      .rec_m     (m_q),
      .rec_w     (w_q),
      .stall_req (req_e_rs),
      .fwd_sel   (sel_e_rs)
   );

   hazard_match u_match_e_rt (
      .addr      (e_q.rt),
      .use_t     (e_q.t_rt),
      .rec_e     (REC_NONE),
      .rec_m     (m_q),
      .rec_w     (w_q),
      .stall_req (req_e_rt),
      .fwd_sel   (sel_e_rt)
   );

   hazard_match u_match_m_rt (
      .addr      (m_q.rt),
      .use_t     (m_q.t_rt),
      .rec_e     (REC_NONE),
      .rec_m     (REC_NONE),
      .rec_w     (w_q),
      .stall_req (req_m_rt),
      .fwd_sel   (sel_m_rt)
   );

   assign stall = d_valid & (req_rs | req_rt);

   always_comb begin
      fwd_e_rs = FWD_E_IDEX;
      case (sel_e_rs)
         FWD_D_M: fwd_e_rs = FWD_E_M;
         FWD_D_W: fwd_e_rs = FWD_E_W;
         default: fwd_e_rs = FWD_E_IDEX;
      endcase
      fwd_e_rt = FWD_E_IDEX;
      case (sel_e_rt)
         FWD_D_M: fwd_e_rt = FWD_E_M;
         FWD_D_W: fwd_e_rt = FWD_E_W;
         default: fwd_e_rt = FWD_E_IDEX;
      endcase
      fwd_m_rt = (sel_m_rt == FWD_D_W) ? FWD_M_W : FWD_M_EXMEM;
   end

   // Bubbles and invalid slots are loaded fully cleared so they select nothing.
   always_comb begin
      e_d = REC_NONE;
      if (d_valid && !stall) begin
         e_d.valid = 1'b1;
         e_d.rs    = d_rs;
         e_d.rt    = d_rt;
         e_d.t_rs  = d_t_rs;
         e_d.t_rt  = d_t_rt;
         e_d.dst   = d_dst;
         e_d.t     = d_t;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e_q         <= REC_NONE;
         m_q         <= REC_NONE;
         w_q         <= REC_NONE;
         stall_cnt_q <= '0;
      end else begin
         e_q         <= e_d;
         m_q         <= e_q;
         w_q         <= m_q;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

   logic unused_req;
   assign unused_req = req_e_rs ^ req_e_rt ^ req_m_rt;

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: table of per-cycle vectors through a scoreboard queue,
// a narrow-counter instance for saturation, and an asynchronous reset mid-stall.
module tb_hazard_tracker;

   typedef struct {
      logic       v;
      logic [4:0] rs, rt, dst;
      logic [3:0] trs, trt, t;
      logic       es;
      logic [1:0] fdrs, fdrt, fers, fert;
      logic       fmrt;
      logic       ce;   // E selects are checked (skipped while E holds a bubble)
   } vec_t;

   logic        clk, reset_n;
   logic        d_valid;
   logic [4:0]  d_rs, d_rt, d_dst;
   logic [3:0]  d_t_rs, d_t_rt, d_t;
   logic        stall, fwd_m_rt;
   logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
   logic [31:0] stall_cnt;

   logic        stall_s, sat_unused_fmrt;
   logic [1:0]  sat_unused_fdrs, sat_unused_fdrt, sat_unused_fers, sat_unused_fert;
   logic [1:0]  stall_cnt_s;

   int n_pass, n_total;
   int exp_cnt, exp_cnt_s;
   vec_t tbl[$];
   vec_t sb[$];

   hazard_tracker #(.CNT_W(32)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .d_valid   (d_valid),
      .d_rs      (d_rs),
      .d_rt      (d_rt),
      .d_dst     (d_dst),
      .d_t_rs    (d_t_rs),
      .d_t_rt    (d_t_rt),
      .d_t       (d_t),
      .stall     (stall),
      .fwd_d_rs  (fwd_d_rs),
      .fwd_d_rt  (fwd_d_rt),
      .fwd_e_rs  (fwd_e_rs),
      .fwd_e_rt  (fwd_e_rt),
      .fwd_m_rt  (fwd_m_rt),
      .stall_cnt (stall_cnt)
   );

   hazard_tracker #(.CNT_W(2)) u_dut_sat (
      .clk       (clk),
      .reset_n   (reset_n),
      .d_valid   (d_valid),
      .d_rs      (d_rs),
      .d_rt      (d_rt),
      .d_dst     (d_dst),
      .d_t_rs    (d_t_rs),
      .d_t_rt    (d_t_rt),
      .d_t       (d_t),
      .stall     (stall_s),
      .fwd_d_rs  (sat_unused_fdrs),
      .fwd_d_rt  (sat_unused_fdrt),
      .fwd_e_rs  (sat_unused_fers),
      .fwd_e_rt  (sat_unused_fert),
      .fwd_m_rt  (sat_unused_fmrt),
      .stall_cnt (stall_cnt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(int v, int rs, int rt, int dst, int trs, int trt, int t,
                               int es, int fdrs, int fdrt, int fers, int fert, int fmrt,
                               int ce);
      vec_t x;
      x.v = 1'(v);     x.rs = 5'(rs);   x.rt = 5'(rt);   x.dst = 5'(dst);
      x.trs = 4'(trs); x.trt = 4'(trt); x.t = 4'(t);     x.es = 1'(es);
      x.fdrs = 2'(fdrs); x.fdrt = 2'(fdrt); x.fers = 2'(fers); x.fert = 2'(fert);
      x.fmrt = 1'(fmrt); x.ce = 1'(ce);
      return x;
   endfunction

   // Bubble in D, with expected E/M selects given
   function automatic vec_t nop(int fers, int fmrt);
      return mk(0, 0, 0, 0, 15, 15, 15, 0, 0, 0, fers, 0, fmrt, 1);
   endfunction

   task automatic chk(input int idx, input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %0d %s: got %0d expected %0d", idx, name, act, exp);
   endtask

   task automatic drive(input vec_t x);
      d_valid = x.v;   d_rs = x.rs;    d_rt = x.rt;  d_dst = x.dst;
      d_t_rs = x.trs;  d_t_rt = x.trt; d_t = x.t;
   endtask

   initial begin
      vec_t e;
      n_pass = 0; n_total = 0; exp_cnt = 0; exp_cnt_s = 0;
      reset_n = 1'b0;
      drive(nop(0, 0));

      // load-use
      tbl.push_back(mk(1, 29, 8, 8, 1, 15, 3,   0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 8, 10, 11, 1, 1, 2,   1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 8, 10, 11, 1, 1, 2,   0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(nop(2, 0));
      tbl.push_back(nop(0, 0));
      tbl.push_back(nop(0, 0));
      // ALU to ALU
      tbl.push_back(mk(1, 1, 2, 9, 1, 1, 2,     0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 9, 3, 12, 1, 1, 2,    0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(nop(1, 0));
      tbl.push_back(nop(0, 0));
      tbl.push_back(nop(0, 0));
      // branch after ALU
      tbl.push_back(mk(1, 1, 2, 4, 1, 1, 2,     0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 4, 0, 0, 0, 0, 15,    1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 4, 0, 0, 0, 0, 15,    0, 2, 0, 0, 0, 0, 0));
      tbl.push_back(nop(2, 0));
      tbl.push_back(nop(0, 0));
      tbl.push_back(nop(0, 0));
      // jal then jr
      tbl.push_back(mk(1, 0, 0, 31, 15, 15, 0,  0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 31, 0, 0, 0, 15, 15,  0, 1, 0, 0, 0, 0, 1));
      tbl.push_back(nop(1, 0));
      tbl.push_back(nop(0, 0));
      tbl.push_back(nop(0, 0));
      // sw data after lw
      tbl.push_back(mk(1, 29, 5, 5, 1, 15, 3,   0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 29, 5, 0, 1, 2, 15,   0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(nop(0, 0));
      tbl.push_back(nop(0, 1));
      tbl.push_back(nop(0, 0));
      tbl.push_back(nop(0, 0));
      // writes/reads of $0
      tbl.push_back(mk(1, 0, 0, 0, 1, 15, 3,    0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 0, 0, 2, 1, 1, 2,     0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(nop(0, 0));
      // d_valid=0 masks stall; M-stage stall; W never stalls
      tbl.push_back(mk(1, 0, 0, 7, 15, 15, 3,   0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 7, 0, 0, 1, 15, 15,   0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 7, 0, 0, 0, 15, 15,   1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 7, 0, 0, 0, 15, 15,   0, 3, 0, 0, 0, 0, 0));
      tbl.push_back(nop(0, 0));
      // successive writes to $6: nearest stage wins
      tbl.push_back(mk(1, 1, 2, 6, 1, 1, 2,     0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 6, 6, 6, 1, 1, 2,     0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 6, 0, 0, 0, 15, 15,   1, 0, 0, 1, 1, 0, 1));
      tbl.push_back(mk(1, 6, 0, 0, 0, 15, 15,   0, 2, 0, 0, 0, 1, 0));
      tbl.push_back(nop(2, 0));

      #12;
      chk(-1, "rst_stall", int'(stall), 0);
      chk(-1, "rst_cnt", int'(stall_cnt), 0);
      chk(-1, "rst_fwd", int'({fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt}), 0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         drive(tbl[i]);
         sb.push_back(tbl[i]);
         #2;
         e = sb.pop_front();
         chk(i, "stall", int'(stall), int'(e.es));
         chk(i, "fwd_d_rs", int'(fwd_d_rs), int'(e.fdrs));
         chk(i, "fwd_d_rt", int'(fwd_d_rt), int'(e.fdrt));
         if (e.ce) begin
            chk(i, "fwd_e_rs", int'(fwd_e_rs), int'(e.fers));
            chk(i, "fwd_e_rt", int'(fwd_e_rt), int'(e.fert));
         end
         chk(i, "fwd_m_rt", int'(fwd_m_rt), int'(e.fmrt));
         chk(i, "stall_cnt", int'(stall_cnt), exp_cnt);
         chk(i, "stall_cnt_sat", int'(stall_cnt_s), exp_cnt_s);
         chk(i, "stall_sat", int'(stall_s), int'(e.es));
         if (e.es) begin
            exp_cnt++;
            if (exp_cnt_s < 3) exp_cnt_s++;
         end
      end
      @(negedge clk);
      chk(99, "stall_cnt_end", int'(stall_cnt), exp_cnt);
      chk(99, "stall_cnt_sat_end", int'(stall_cnt_s), 3);

      // asynchronous reset while stalled
      drive(mk(1, 0, 0, 8, 15, 15, 3, 0, 0, 0, 0, 0, 0, 1));
      @(negedge clk);
      drive(mk(1, 8, 0, 11, 1, 15, 2, 0, 0, 0, 0, 0, 0, 1));
      #2;
      chk(100, "midstall_stall", int'(stall), 1);
      reset_n = 1'b0;
      #1;
      chk(100, "async_rst_stall", int'(stall), 0);
      chk(100, "async_rst_cnt", int'(stall_cnt), 0);
      chk(100, "async_rst_cnt_sat", int'(stall_cnt_s), 0);
      chk(100, "async_rst_fwd", int'({fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt}), 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #2;
      chk(101, "post_rst_stall", int'(stall), 0);
      @(negedge clk);
      #2;
      chk(101, "post_rst_cnt", int'(stall_cnt), 0);
      chk(101, "post_rst_fwd_e_rs", int'(fwd_e_rs), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
